// File: rtl/multicycle_decoder.sv
// rtl/multicycle_decoder.sv - multicycle ARM control unit (Moore FSM + ALU decode)
//
// Optional feature macro: MC_DEC_CMP_EN
//   defined   : CMP (cmd 1010) -> SUB, FlagW=11; TST (cmd 1000) -> AND, FlagW=10;
//               both finish in EXECUTE and skip ALUWB (no register write).
//   undefined : cmd 1010/1000 are unsupported (ADD, FlagW=00, normal ALUWB path).
//
// Parameter:
//   ALU_CTRL_W  ALUControl width, 2 or 3 (3 adds EOR for cmd 0001)
//
// Ports:
//   clk, reset      clock; synchronous active-high reset to FETCH
//   mem_ready       memory completes the current access this cycle
//   Op, Funct, Rd   instruction fields from the instruction register
//   PCS, NextPC     PC write requests (branch/R15 writeback, PC+4)
//   RegW, MemW      register / memory write requests
//   IRWrite         instruction register load
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc   datapath muxes
//   ALUControl      ALU operation (ADD=0 SUB=1 AND=2 ORR=3 EOR=4)
//   FlagW           [1]=NZ write, [0]=CV write
//   state           current state code (debug)
module multicycle_decoder #(
    parameter int ALU_CTRL_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_ready,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    output logic                  PCS,
    output logic                  NextPC,
    output logic                  RegW,
    output logic                  MemW,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [1:0]            FlagW,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    state_t     state_q;
    state_t     state_d;

    logic [3:0] cmd;
    logic       s_bit;
    logic [2:0] dec_op;
    logic [1:0] dec_flagw;
    logic       dec_flag_only;
    logic [2:0] alu_op;

    assign cmd    = Funct[4:1];
    assign s_bit  = Funct[0];
    assign state  = state_q;
    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01) && !Funct[0], Op == 2'b10};

    // Command decode, used only while in an EXECUTE state.
    always_comb begin
        dec_op        = ALU_ADD;
        dec_flagw     = 2'b00;
        dec_flag_only = 1'b0;
        case (cmd)
            4'b0100: begin dec_op = ALU_ADD; dec_flagw = {s_bit, s_bit}; end
            4'b0010: begin dec_op = ALU_SUB; dec_flagw = {s_bit, s_bit}; end
            4'b0000: begin dec_op = ALU_AND; dec_flagw = {s_bit, 1'b0};  end
            4'b1100: begin dec_op = ALU_ORR; dec_flagw = {s_bit, 1'b0};  end
            4'b0001: begin
                // EOR is only encodable with a 3-bit ALUControl
                if (ALU_CTRL_W == 3) begin
                    dec_op    = ALU_EOR;
                    dec_flagw = {s_bit, 1'b0};
                end
            end
`ifdef MC_DEC_CMP_EN
            4'b1010: begin dec_op = ALU_SUB; dec_flagw = 2'b11; dec_flag_only = 1'b1; end
            4'b1000: begin dec_op = ALU_AND; dec_flagw = 2'b10; dec_flag_only = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu_op    = ALU_ADD;
        FlagW     = 2'b00;
        PCS       = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                MemW    = 1'b1;
                state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                alu_op  = dec_op;
                FlagW   = dec_flagw;
                // flag-only compares retire here without a writeback cycle
                state_d = dec_flag_only ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegW = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
            end
            default: state_d = S_FETCH;
        endcase

        PCS = (RegW && (Rd == 4'hF)) || (state_q == S_BRANCH);

        // No write strobe may escape while reset is held.
        if (reset) begin
            PCS     = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            IRWrite = 1'b0;
            FlagW   = 2'b00;
        end
    end

    assign ALUControl = ALU_CTRL_W'(alu_op);

endmodule

// File: tb/tb_multicycle_decoder.sv
// tb/tb_multicycle_decoder.sv - self-checking bench for multicycle_decoder (2- and 3-bit ALU)
module tb_multicycle_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       mem_ready;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;

    logic       pcs2, nextpc2, regw2, memw2, irwrite2, adrsrc2, alusrca2;
    logic [1:0] resultsrc2, alusrcb2, immsrc2, regsrc2, flagw2, aluctrl2;
    logic [3:0] state2;
    logic       pcs3, nextpc3, regw3, memw3, irwrite3, adrsrc3, alusrca3;
    logic [1:0] resultsrc3, alusrcb3, immsrc3, regsrc3, flagw3;
    logic [2:0] aluctrl3;
    logic [3:0] state3;

    multicycle_decoder #(.ALU_CTRL_W(2)) dut2 (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .Op(Op), .Funct(Funct), .Rd(Rd),
        .PCS(pcs2), .NextPC(nextpc2), .RegW(regw2), .MemW(memw2), .IRWrite(irwrite2),
        .AdrSrc(adrsrc2), .ResultSrc(resultsrc2), .ALUSrcA(alusrca2), .ALUSrcB(alusrcb2),
        .ImmSrc(immsrc2), .RegSrc(regsrc2), .ALUControl(aluctrl2), .FlagW(flagw2), .state(state2)
    );

    multicycle_decoder #(.ALU_CTRL_W(3)) dut3 (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .Op(Op), .Funct(Funct), .Rd(Rd),
        .PCS(pcs3), .NextPC(nextpc3), .RegW(regw3), .MemW(memw3), .IRWrite(irwrite3),
        .AdrSrc(adrsrc3), .ResultSrc(resultsrc3), .ALUSrcA(alusrca3), .ALUSrcB(alusrcb3),
        .ImmSrc(immsrc3), .RegSrc(regsrc3), .ALUControl(aluctrl3), .FlagW(flagw3), .state(state3)
    );

`ifdef MC_DEC_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pcs;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic [2:0] aluctrl;
        logic [1:0] flagw;
        logic [3:0] st;
    } obs_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        int         fwaits;
        int         mwaits;
    } instr_t;

    int   tests = 0;
    int   fails = 0;
    obs_t obs2_q[$];
    obs_t obs3_q[$];
    obs_t exp2_q[$];
    obs_t exp3_q[$];

    function automatic obs_t sample2();
        return {pcs2, nextpc2, regw2, memw2, irwrite2, adrsrc2, resultsrc2, alusrca2,
                alusrcb2, immsrc2, regsrc2, {1'b0, aluctrl2}, flagw2, state2};
    endfunction

    function automatic obs_t sample3();
        return {pcs3, nextpc3, regw3, memw3, irwrite3, adrsrc3, resultsrc3, alusrca3,
                alusrcb3, immsrc3, regsrc3, aluctrl3, flagw3, state3};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Data-processing command table: operation, flag writes, and whether it writes back.
    function automatic void alu_ref(input logic [3:0] cmd, input logic s, input bit w3,
                                    output logic [2:0] ctrl, output logic [1:0] fw, output bit no_wb);
        ctrl = 3'd0; fw = 2'b00; no_wb = 1'b0;
        if (cmd == 4'b0100)                begin ctrl = 3'd0; fw = {s, s};    end
        else if (cmd == 4'b0010)           begin ctrl = 3'd1; fw = {s, s};    end
        else if (cmd == 4'b0000)           begin ctrl = 3'd2; fw = {s, 1'b0}; end
        else if (cmd == 4'b1100)           begin ctrl = 3'd3; fw = {s, 1'b0}; end
        else if (cmd == 4'b0001 && w3)     begin ctrl = 3'd4; fw = {s, 1'b0}; end
        else if (cmd == 4'b1010 && CMP_EN) begin ctrl = 3'd1; fw = 2'b11; no_wb = 1'b1; end
        else if (cmd == 4'b1000 && CMP_EN) begin ctrl = 3'd2; fw = 2'b10; no_wb = 1'b1; end
    endfunction

    // Expected outputs for one cycle spent in the step named by code.
    function automatic obs_t model_out(input int code, input logic mr, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd, input bit w3);
        obs_t e;
        bit   nowb;
        e        = '0;
        e.st     = 4'(code);
        e.immsrc = op;
        e.regsrc = {op == 2'b01 && !f[0], op == 2'b10};
        case (code)
            0: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
                     e.irwrite = mr; e.nextpc = mr; end
            1: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
            2: e.alusrcb = 2'b01;
            3: e.adrsrc = 1'b1;
            4: begin e.resultsrc = 2'b01; e.regw = 1'b1; end
            5: begin e.adrsrc = 1'b1; e.memw = 1'b1; end
            6, 7: begin
                e.alusrcb = (code == 7) ? 2'b01 : 2'b00;
                alu_ref(f[4:1], f[0], w3, e.aluctrl, e.flagw, nowb);
            end
            8: e.regw = 1'b1;
            9: begin e.alusrcb = 2'b01; e.resultsrc = 2'b10; e.pcs = 1'b1; end
            default: ;
        endcase
        if (e.regw && rd == 4'hF) e.pcs = 1'b1;
        return e;
    endfunction

    // Runs one instruction from FETCH, recording observed and predicted outputs per cycle.
    task automatic play(input instr_t in);
        int         codes[$];
        logic       mrs[$];
        logic [2:0] c;
        logic [1:0] fw;
        bit         nowb;
        obs2_q.delete(); obs3_q.delete(); exp2_q.delete(); exp3_q.delete();
        for (int k = 0; k < in.fwaits; k++) begin codes.push_back(0); mrs.push_back(1'b0); end
        codes.push_back(0); mrs.push_back(1'b1);
        codes.push_back(1); mrs.push_back(rbit());
        if (in.op == 2'b10) begin
            codes.push_back(9); mrs.push_back(rbit());
        end else if (in.op == 2'b01) begin
            codes.push_back(2); mrs.push_back(rbit());
            for (int k = 0; k < in.mwaits; k++) begin
                codes.push_back(in.funct[0] ? 3 : 5); mrs.push_back(1'b0);
            end
            codes.push_back(in.funct[0] ? 3 : 5); mrs.push_back(1'b1);
            if (in.funct[0]) begin codes.push_back(4); mrs.push_back(rbit()); end
        end else if (in.op == 2'b00) begin
            codes.push_back(in.funct[5] ? 7 : 6); mrs.push_back(rbit());
            alu_ref(in.funct[4:1], in.funct[0], 1'b0, c, fw, nowb);
            if (!nowb) begin codes.push_back(8); mrs.push_back(rbit()); end
        end
        for (int i = 0; i < codes.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin Op = in.op; Funct = in.funct; Rd = in.rd; end
            mem_ready = mrs[i];
            #1;
            obs2_q.push_back(sample2());
            obs3_q.push_back(sample3());
            exp2_q.push_back(model_out(codes[i], mrs[i], in.op, in.funct, in.rd, 1'b0));
            exp3_q.push_back(model_out(codes[i], mrs[i], in.op, in.funct, in.rd, 1'b1));
        end
    endtask

    function automatic instr_t rand_instr(input bit waits);
        instr_t     r;
        logic [3:0] cmds[8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000, 4'b1111};
        r.op     = 2'($urandom_range(0, 3));
        r.funct  = 6'($urandom);
        if (r.op == 2'b00) r.funct[4:1] = cmds[$urandom_range(0, 7)];
        r.rd     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        r.fwaits = waits ? int'($urandom_range(0, 2)) : 0;
        r.mwaits = waits ? int'($urandom_range(0, 3)) : 0;
        return r;
    endfunction

    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b1; Op = 2'b00; Funct = 6'b001000; Rd = 4'd3;
        @(posedge clk);
        @(negedge clk); #1;
        tests++;
        if ({state2, state3} !== 8'h00) begin
            fails++; $display("FAIL reset_state got %h/%h expected 0/0", state2, state3);
        end
        tests++;
        if ({irwrite2, nextpc2, pcs2, regw2, memw2, flagw2} !== 7'b0) begin
            fails++; $display("FAIL reset_strobes got %b expected 0000000",
                              {irwrite2, nextpc2, pcs2, regw2, memw2, flagw2});
        end
        reset = 1'b0; #1;
        tests++;
        if ({irwrite2, nextpc2} !== 2'b11) begin
            fails++; $display("FAIL fetch_ready_strobes got %b expected 11", {irwrite2, nextpc2});
        end
        mem_ready = 1'b0;
        @(negedge clk); #1;
        tests++;
        if ({state2, irwrite2, nextpc2} !== 6'b0) begin
            fails++; $display("FAIL fetch_stall got state %0d ir %b expected state 0 ir 0",
                              state2, irwrite2);
        end
    endtask

    task automatic test_directed;
        instr_t tbl[12] = '{
            '{2'b00, 6'b001000, 4'd3,  0, 0},   // ADD R3
            '{2'b01, 6'b011001, 4'd2,  0, 3},   // LDR, 3 wait cycles
            '{2'b01, 6'b011000, 4'd4,  0, 1},   // STR, 1 wait cycle
            '{2'b10, 6'b100000, 4'd0,  0, 0},   // B
            '{2'b00, 6'b000101, 4'hF,  0, 0},   // SUBS PC
            '{2'b00, 6'b000011, 4'd1,  0, 0},   // EORS
            '{2'b00, 6'b010101, 4'd0,  0, 0},   // CMP
            '{2'b00, 6'b110001, 4'd5,  0, 0},   // TST imm
            '{2'b11, 6'b000000, 4'd0,  0, 0},   // NOP class
            '{2'b00, 6'b111000, 4'd7,  2, 0},   // ORR imm, fetch waits
            '{2'b01, 6'b011001, 4'hF,  1, 0},   // LDR PC
            '{2'b00, 6'b011111, 4'd6,  0, 0}    // unsupported cmd with S
        };
        for (int t = 0; t < 12; t++) begin
            play(tbl[t]);
            for (int i = 0; i < obs2_q.size(); i++) begin
                tests++;
                if (obs2_q[i] !== exp2_q[i]) begin
                    fails++; $display("FAIL directed%0d step %0d w2 got %h expected %h",
                                      t, i, obs2_q[i], exp2_q[i]);
                end
                tests++;
                if (obs3_q[i] !== exp3_q[i]) begin
                    fails++; $display("FAIL directed%0d step %0d w3 got %h expected %h",
                                      t, i, obs3_q[i], exp3_q[i]);
                end
            end
        end
    endtask

    // Literal state sequences and latencies, independent of the model.
    task automatic test_sequences;
        instr_t seqs[3] = '{
            '{2'b00, 6'b001000, 4'd3, 0, 0},
            '{2'b01, 6'b011001, 4'd2, 0, 3},
            '{2'b10, 6'b000000, 4'd0, 0, 0}
        };
        logic [31:0] want[3] = '{32'h0168, 32'h01233334, 32'h019};
        int          lens[3] = '{4, 8, 3};
        logic [31:0] got;
        for (int t = 0; t < 3; t++) begin
            play(seqs[t]);
            got = '0;
            foreach (obs2_q[i]) got = {got[27:0], obs2_q[i].st};
            tests++;
            if (obs2_q.size() != lens[t] || got !== want[t]) begin
                fails++; $display("FAIL sequence%0d got %h len %0d expected %h len %0d",
                                  t, got, obs2_q.size(), want[t], lens[t]);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 8; t++) begin
            play(rand_instr(1'b0));
            for (int i = 0; i < obs2_q.size(); i++) begin
                tests++;
                if (obs2_q[i] !== exp2_q[i] || obs3_q[i] !== exp3_q[i]) begin
                    fails++; $display("FAIL b2b%0d step %0d got %h/%h expected %h/%h",
                                      t, i, obs2_q[i], obs3_q[i], exp2_q[i], exp3_q[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) begin
            play(rand_instr(1'b1));
            for (int i = 0; i < obs2_q.size(); i++) begin
                tests++;
                if (obs2_q[i] !== exp2_q[i] || obs3_q[i] !== exp3_q[i]) begin
                    fails++; $display("FAIL rand%0d step %0d got %h/%h expected %h/%h",
                                      t, i, obs2_q[i], obs3_q[i], exp2_q[i], exp3_q[i]);
                end
            end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        tests++;
        if (state2 !== 4'd0) begin
            fails++; $display("FAIL rand_return got state %0d expected 0", state2);
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        Op = 2'b00; Funct = 6'b000101; Rd = 4'hF; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({state2, regw2, pcs2, flagw2} !== {4'd8, 1'b1, 1'b1, 2'b00}) begin
            fails++; $display("FAIL aluwb_pc got state %0d regw %b pcs %b expected 8 1 1",
                              state2, regw2, pcs2);
        end
        reset = 1'b1; #1;
        tests++;
        if ({regw2, pcs2, regw3, pcs3} !== 4'b0) begin
            fails++; $display("FAIL abort_aluwb_strobes got %b expected 0000",
                              {regw2, pcs2, regw3, pcs3});
        end
        @(negedge clk); #1;
        tests++;
        if ({state2, state3, irwrite2, nextpc2} !== 10'b0) begin
            fails++; $display("FAIL abort_aluwb_next got %0d/%0d ir %b expected 0/0 ir 0",
                              state2, state3, irwrite2);
        end
        reset = 1'b0; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0; reset = 1'b1; #1;
        tests++;
        if ({state2, memw2, memw3} !== {4'd5, 2'b00}) begin
            fails++; $display("FAIL abort_memwrite got state %0d memw %b expected 5 0",
                              state2, memw2);
        end
        @(negedge clk); #1;
        tests++;
        if (state2 !== 4'd0) begin
            fails++; $display("FAIL abort_memwrite_next got %0d expected 0", state2);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
        test_reset;
        test_directed;
        test_sequences;
        test_back_to_back;
        test_random;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_decoder.md
# multicycle_decoder

Multicycle control unit for the ARM datapath. It replaces the single-cycle decode path with a Moore state machine that sequences fetch, decode, memory and execute steps over several cycles, and stalls on a memory-ready handshake. The ALU decode width is parametrised, and CMP/TST support is optional. Outputs drive the shared-memory multicycle datapath and the downstream conditional-execution logic, which gates PCS, RegW and MemW with CondEx.

## Interface
- ALU_CTRL_W, 2, ALUControl width; legal values 2 or 3. A value of 3 adds EOR.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; state goes to FETCH
- mem_ready  in  1  memory completes the current access this cycle
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S/L
- Rd  in  4  instr[15:12]
- PCS  out  1  PC write request from branch or R15 writeback (unconditional)
- NextPC  out  1  PC+4 write, never condition-gated
- RegW  out  1  register write request (unconditional)
- MemW  out  1  memory write request (unconditional)
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0=PC, 1=ALUResult
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  Op (combinational)
- RegSrc  out  2  {Op==01 & ~Funct[0], Op==10} (combinational)
- ALUControl  out  ALU_CTRL_W  ALU operation
- FlagW  out  2  [1]=NZ write, [0]=CV write
- state  out  4  current state code, debug only

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10–15 are illegal and return to FETCH.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10. IRWrite and NextPC equal mem_ready. The FSM stays in FETCH while mem_ready=0 and moves to DECODE when mem_ready=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by instruction class:
  - Op=01 → MEMADR
  - Op=00 & ~Funct[5] → EXECUTER
  - Op=00 & Funct[5] → EXECUTEI
  - Op=10 → BRANCH
  - Op=11 → FETCH (treated as a NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALU ADD. Next is MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. The FSM holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemW=1 every cycle in the state. The FSM holds until mem_ready, then goes to FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU decode active. Next is ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALU decode active. Next is ALUWB.
- ALUWB: ResultSrc=00, RegW=1, then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALU ADD, ResultSrc=10, then FETCH.
- PCS = (RegW & Rd==4'hF) | (state==BRANCH).
- ALU decode applies only in the EXECUTE states; elsewhere ALUControl=ADD and FlagW=00.
  - cmd 0100 → ADD=0
  - cmd 0010 → SUB=1
  - cmd 0000 → AND=2
  - cmd 1100 → ORR=3
  - cmd 0001 → EOR=4, only when ALU_CTRL_W=3
  - Any other cmd → ADD with FlagW=00.
- FlagW[1]=S.
- FlagW[0]=S & (op is ADD or SUB).
- Outputs not listed for a state are 0. Fields that are don't-care are driven to 0.

## Timing
- All control outputs are combinational from the state register and the instruction inputs (Moore on state, Mealy only on mem_ready).
- While reset=1: PCS, NextPC, RegW, MemW, IRWrite and FlagW are forced to 0. On the first edge with reset=1, state becomes FETCH.
- Reset asserted mid-instruction aborts the instruction at the next edge, with no partial write.
- Minimum latency with mem_ready held high:
  - data-processing and LDR: 4/5 cycles (DP=4, LDR=5)
  - STR and B: 4/3 cycles (STR=4, B=3)
- A wait state adds exactly one cycle per low mem_ready cycle in FETCH, MEMREAD or MEMWRITE.
- Op, Funct and Rd must be stable from DECODE until the return to FETCH; the IR guarantees this.

## Configuration
- MC_DEC_CMP_EN defined:
  - cmd 1010 (CMP) decodes to SUB and cmd 1000 (TST) decodes to AND.
  - FlagW is forced to full write: 11 for CMP, 10 for TST.
  - EXECUTER/EXECUTEI go directly to FETCH, skipping ALUWB, so RegW and PCS stay 0.
- MC_DEC_CMP_EN undefined: cmd 1010 and 1000 are unsupported commands (ADD, FlagW=00) and take the normal ALUWB path.

## Test plan
- Reset, then ADD R3 (Op=00, Funct=001000, Rd=3), mem_ready=1 → state 0,1,6,8,0. IRWrite and NextPC are high in cycle 0 only; ALUControl=0 in EXECUTER; RegW=1 only in ALUWB; PCS=0.
- LDR (Op=01, Funct=011001) with mem_ready low for 3 cycles in MEMREAD → state 0,1,2,3,3,3,3,4. ResultSrc=01 and RegW=1 in MEMWB.
- STR (Funct=011000) with mem_ready low for 1 cycle → MEMWRITE lasts 2 cycles with MemW=1 and AdrSrc=1, then FETCH; RegW stays 0.
- B (Op=10) → 0,1,9,0. PCS=1 in BRANCH; ResultSrc=10.
- SUBS PC (Funct=000101, Rd=15), EXECUTER → ALUControl=1, FlagW=11. In ALUWB, PCS=1 and RegW=1. Asserting reset in ALUWB → next state 0 and RegW=0 during reset.
- With MC_DEC_CMP_EN, CMP (Funct=010101) → 0,1,6,0 with FlagW=11 and RegW never 1. With ALU_CTRL_W=3, EORS (Funct=000011) → ALUControl=4, FlagW=10.
